if_stage: RTL and testbench



---
 rtl/if_stage_if.sv | 45 ++++
 rtl/if_stage.sv | 129 ++++++++++++
 tb/tb_if_stage.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage_if
//  Description : Control, instruction-memory load and IF/ID output bundle for
//                the instruction-fetch stage. The master side drives stall,
//                flush and memory loads; the slave side is the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
interface if_stage_if #(
    parameter int XLEN       = 64,
    parameter int IMEM_WORDS = 64
) ();
    localparam int c_AW = $clog2(IMEM_WORDS);

    // Hazard / branch control
    logic                stall;
    logic                flush;
    logic [XLEN-1:0]     branch_target;

    // Instruction memory load port
    logic                imem_we;
    logic [c_AW-1:0]     imem_waddr;
    logic [31:0]         imem_wdata;

    // Fetch state and IF/ID register towards decode
    logic [XLEN-1:0]     pc_out;
    logic [XLEN-1:0]     ifid_pc;
    logic [31:0]         ifid_instruction;
    logic                ifid_valid;
    logic                halted;
    logic [31:0]         fetch_count;

    modport master (
        output stall, flush, branch_target,
        output imem_we, imem_waddr, imem_wdata,
        input  pc_out, ifid_pc, ifid_instruction, ifid_valid, halted, fetch_count
    );

    modport slave (
        input  stall, flush, branch_target,
        input  imem_we, imem_waddr, imem_wdata,
        output pc_out, ifid_pc, ifid_instruction, ifid_valid, halted, fetch_count
    );
endinterface
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage. Holds the PC, a word-addressed
//                instruction memory with a synchronous load port, and the
//                IF/ID pipeline register. Honours stall and flush/redirect and
//                stops fetching on an all-zero instruction word.
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter int              XLEN       = 64,
    parameter int              IMEM_WORDS = 64,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [31:0]     NOP        = 32'h00000013
) (
    input  wire logic   clk,
    input  wire logic   reset,
    if_stage_if.slave   bus
);
    localparam int c_AW = $clog2(IMEM_WORDS);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [31:0]       imem_q [IMEM_WORDS];

    state_t            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   ifid_pc_q;
    logic [31:0]       ifid_instr_q;
    logic              ifid_valid_q;
    logic [31:0]       fetch_count_q;

    // ------------------------------------------------------------------------
    // Combinational fetch path
    // ------------------------------------------------------------------------
    logic              w_in_range;
    logic [31:0]       w_word;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_redirect_pc;
    logic [31:0]       w_count_inc;

    // Anything past the end of the memory fetches a bubble instead of aliasing.
    assign w_in_range    = ((pc_q >> 2) < XLEN'(IMEM_WORDS));
    assign w_word        = w_in_range ? imem_q[pc_q[2 +: c_AW]] : NOP;
    assign w_pc_plus4    = pc_q + XLEN'(4);
    // Redirect targets are forced to word alignment; the low two bits are dropped.
    assign w_redirect_pc = bus.branch_target & ~XLEN'(3);
    // Delivered-instruction counter sticks at all-ones instead of wrapping.
    assign w_count_inc   = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                            : fetch_count_q + 32'd1;

    // Instruction memory load port; not reset, read-before-write with the fetch.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem_q[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // Fetch FSM with PC and IF/ID register; priority is flush, then stall, then state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            ifid_pc_q     <= '0;
            ifid_instr_q  <= NOP;
            ifid_valid_q  <= 1'b0;
            fetch_count_q <= '0;
        end else if (bus.flush) begin
            // Taken branch: squash the younger instruction and restart at the target.
            state_q      <= ST_RUN;
            pc_q         <= w_redirect_pc;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
            ifid_valid_q <= 1'b0;
        end else if (bus.stall) begin
            // Hazard stall: everything holds.
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!w_in_range) begin
                        // Unbacked address: emit a bubble and keep walking.
                        pc_q         <= w_pc_plus4;
                        ifid_pc_q    <= '0;
                        ifid_instr_q <= NOP;
                        ifid_valid_q <= 1'b0;
                    end else if (w_word == 32'h0000_0000) begin
                        // Zero word marks end of program: park the PC on it.
                        state_q      <= ST_HALTED;
                        ifid_pc_q    <= '0;
                        ifid_instr_q <= NOP;
                        ifid_valid_q <= 1'b0;
                    end else begin
                        pc_q          <= w_pc_plus4;
                        ifid_pc_q     <= pc_q;
                        ifid_instr_q  <= w_word;
                        ifid_valid_q  <= 1'b1;
                        fetch_count_q <= w_count_inc;
                    end
                end
                ST_HALTED: begin
                    ifid_pc_q    <= '0;
                    ifid_instr_q <= NOP;
                    ifid_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (all come straight from registers)
    // ------------------------------------------------------------------------
    assign bus.pc_out           = pc_q;
    assign bus.ifid_pc          = ifid_pc_q;
    assign bus.ifid_instruction = ifid_instr_q;
    assign bus.ifid_valid       = ifid_valid_q;
    assign bus.halted           = (state_q == ST_HALTED);
    assign bus.fetch_count      = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;
    localparam logic [31:0] c_NOP = 32'h00000013;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [31:0] prog [8];

    if_stage_if #(.XLEN(64), .IMEM_WORDS(64)) bus ();

    if_stage #(
        .XLEN       (64),
        .IMEM_WORDS (64),
        .RESET_PC   (64'h0),
        .NOP        (32'h00000013)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.branch_target = '0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;
        for (int i = 0; i < 8; i++) begin
            bus.imem_we = 1'b1; bus.imem_waddr = 6'(i); bus.imem_wdata = prog[i];
            tick();
        end
        bus.imem_we = 1'b0;
        checks++; if (bus.pc_out !== 64'h0) begin errors++; $display("FAIL rst_hold_pc: got %h want %h", bus.pc_out, 64'h0); end
        reset = 1'b0;
        repeat (6) tick();
        checks++; if (bus.pc_out !== 64'h18) begin errors++; $display("FAIL run_pc: got %h want %h", bus.pc_out, 64'h18); end
        checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("FAIL run_count: got %0d want 6", bus.fetch_count); end
        checks++; if (bus.ifid_instruction !== prog[5]) begin errors++; $display("FAIL run_instr: got %h want %h", bus.ifid_instruction, prog[5]); end
        // Asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.pc_out !== 64'h0) begin errors++; $display("FAIL async_pc: got %h want 0", bus.pc_out); end
        checks++; if (bus.ifid_pc !== 64'h0) begin errors++; $display("FAIL async_ifid_pc: got %h want 0", bus.ifid_pc); end
        checks++; if (bus.ifid_instruction !== c_NOP) begin errors++; $display("FAIL async_instr: got %h want %h", bus.ifid_instruction, c_NOP); end
        checks++; if (bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", bus.ifid_valid); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL async_halted: got %b want 0", bus.halted); end
        checks++; if (bus.fetch_count !== 32'd0) begin errors++; $display("FAIL async_count: got %0d want 0", bus.fetch_count); end
        // Plant the halt word at index 3 while in reset
        bus.imem_we = 1'b1; bus.imem_waddr = 6'd3; bus.imem_wdata = 32'h0;
        tick();
        bus.imem_we = 1'b0;
        reset = 1'b0;
        tick();
        checks++; if (bus.ifid_pc !== 64'h0 || bus.ifid_instruction !== prog[0] || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL fetch0: got pc=%h ins=%h v=%b want pc=0 ins=%h v=1", bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid, prog[0]); end
        tick();
        checks++; if (bus.ifid_pc !== 64'h4 || bus.ifid_instruction !== prog[1]) begin errors++; $display("FAIL fetch1: got pc=%h ins=%h want pc=4 ins=%h", bus.ifid_pc, bus.ifid_instruction, prog[1]); end
        tick();
        checks++; if (bus.ifid_pc !== 64'h8 || bus.ifid_instruction !== prog[2]) begin errors++; $display("FAIL fetch2: got pc=%h ins=%h want pc=8 ins=%h", bus.ifid_pc, bus.ifid_instruction, prog[2]); end
        checks++; if (bus.fetch_count !== 32'd3 || bus.pc_out !== 64'hC) begin errors++; $display("FAIL fetch2_state: got cnt=%0d pc=%h want cnt=3 pc=c", bus.fetch_count, bus.pc_out); end
    endtask

    task automatic test_halt();
        tick();
        checks++; if (bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0 || bus.ifid_instruction !== c_NOP) begin errors++; $display("FAIL halt_enter: got h=%b v=%b ins=%h want h=1 v=0 ins=%h", bus.halted, bus.ifid_valid, bus.ifid_instruction, c_NOP); end
        repeat (3) tick();
        checks++; if (bus.pc_out !== 64'hC || bus.halted !== 1'b1 || bus.fetch_count !== 32'd3) begin errors++; $display("FAIL halt_hold: got pc=%h h=%b cnt=%0d want pc=c h=1 cnt=3", bus.pc_out, bus.halted, bus.fetch_count); end
        bus.flush = 1'b1; bus.branch_target = 64'h0;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.halted !== 1'b0 || bus.pc_out !== 64'h0 || bus.ifid_valid !== 1'b0) begin errors++; $display("FAIL halt_exit: got h=%b pc=%h v=%b want h=0 pc=0 v=0", bus.halted, bus.pc_out, bus.ifid_valid); end
        tick();
        checks++; if (bus.ifid_instruction !== prog[0] || bus.fetch_count !== 32'd4) begin errors++; $display("FAIL halt_restart: got ins=%h cnt=%0d want ins=%h cnt=4", bus.ifid_instruction, bus.fetch_count, prog[0]); end
    endtask

    task automatic test_stall();
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        checks++; if (bus.pc_out !== 64'h4 || bus.fetch_count !== 32'd1) begin errors++; $display("FAIL stall_pre: got pc=%h cnt=%0d want pc=4 cnt=1", bus.pc_out, bus.fetch_count); end
        bus.stall = 1'b1;
        repeat (2) tick();
        checks++; if (bus.pc_out !== 64'h4 || bus.ifid_pc !== 64'h0 || bus.fetch_count !== 32'd1 || bus.ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got pc=%h ipc=%h cnt=%0d v=%b want pc=4 ipc=0 cnt=1 v=1", bus.pc_out, bus.ifid_pc, bus.fetch_count, bus.ifid_valid); end
        bus.stall = 1'b0;
        tick();
        checks++; if (bus.ifid_pc !== 64'h4 || bus.ifid_instruction !== prog[1] || bus.pc_out !== 64'h8 || bus.fetch_count !== 32'd2) begin errors++; $display("FAIL stall_resume: got ipc=%h ins=%h pc=%h cnt=%0d want ipc=4 ins=%h pc=8 cnt=2", bus.ifid_pc, bus.ifid_instruction, bus.pc_out, bus.fetch_count, prog[1]); end
    endtask

    task automatic test_flush_stall();
        bus.stall = 1'b1; bus.flush = 1'b1; bus.branch_target = 64'h0E;
        bus.imem_we = 1'b1; bus.imem_waddr = 6'd3; bus.imem_wdata = 32'h00300193;
        tick();
        bus.stall = 1'b0; bus.flush = 1'b0; bus.imem_we = 1'b0;
        checks++; if (bus.pc_out !== 64'hC || bus.ifid_instruction !== c_NOP || bus.ifid_valid !== 1'b0 || bus.ifid_pc !== 64'h0 || bus.fetch_count !== 32'd2) begin errors++; $display("FAIL flush_stall: got pc=%h ins=%h v=%b ipc=%h cnt=%0d want pc=c ins=%h v=0 ipc=0 cnt=2", bus.pc_out, bus.ifid_instruction, bus.ifid_valid, bus.ifid_pc, bus.fetch_count, c_NOP); end
        tick();
        checks++; if (bus.ifid_pc !== 64'hC || bus.ifid_instruction !== 32'h00300193 || bus.ifid_valid !== 1'b1 || bus.fetch_count !== 32'd3) begin errors++; $display("FAIL flush_next: got ipc=%h ins=%h v=%b cnt=%0d want ipc=c ins=00300193 v=1 cnt=3", bus.ifid_pc, bus.ifid_instruction, bus.ifid_valid, bus.fetch_count); end
    endtask

    task automatic test_out_of_range();
        bus.flush = 1'b1; bus.branch_target = 64'h100;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.pc_out !== 64'h100) begin errors++; $display("FAIL oor_target: got %h want 100", bus.pc_out); end
        tick();
        checks++; if (bus.pc_out !== 64'h104 || bus.ifid_valid !== 1'b0 || bus.ifid_instruction !== c_NOP) begin errors++; $display("FAIL oor_step1: got pc=%h v=%b ins=%h want pc=104 v=0 ins=%h", bus.pc_out, bus.ifid_valid, bus.ifid_instruction, c_NOP); end
        tick();
        checks++; if (bus.pc_out !== 64'h108 || bus.halted !== 1'b0 || bus.fetch_count !== 32'd3) begin errors++; $display("FAIL oor_step2: got pc=%h h=%b cnt=%0d want pc=108 h=0 cnt=3", bus.pc_out, bus.halted, bus.fetch_count); end
    endtask

    task automatic test_wrap();
        bus.flush = 1'b1; bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus.flush = 1'b0;
        checks++; if (bus.pc_out !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_align: got %h want fffffffffffffffc", bus.pc_out); end
        tick();
        checks++; if (bus.pc_out !== 64'h0 || bus.ifid_valid !== 1'b0 || bus.fetch_count !== 32'd3) begin errors++; $display("FAIL wrap_zero: got pc=%h v=%b cnt=%0d want pc=0 v=0 cnt=3", bus.pc_out, bus.ifid_valid, bus.fetch_count); end
    endtask

    task automatic test_read_before_write();
        bus.flush = 1'b1; bus.branch_target = 64'h8;
        tick();
        bus.flush = 1'b0;
        bus.imem_we = 1'b1; bus.imem_waddr = 6'd2; bus.imem_wdata = 32'hDEADBEEF;
        tick();
        bus.imem_we = 1'b0;
        checks++; if (bus.ifid_instruction !== prog[2] || bus.ifid_pc !== 64'h8 || bus.fetch_count !== 32'd4) begin errors++; $display("FAIL rbw_old: got ins=%h ipc=%h cnt=%0d want ins=%h ipc=8 cnt=4", bus.ifid_instruction, bus.ifid_pc, bus.fetch_count, prog[2]); end
        bus.flush = 1'b1; bus.branch_target = 64'h8;
        tick();
        bus.flush = 1'b0;
        tick();
        checks++; if (bus.ifid_instruction !== 32'hDEADBEEF || bus.ifid_pc !== 64'h8 || bus.fetch_count !== 32'd5) begin errors++; $display("FAIL rbw_new: got ins=%h ipc=%h cnt=%0d want ins=deadbeef ipc=8 cnt=5", bus.ifid_instruction, bus.ifid_pc, bus.fetch_count); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        prog[0] = 32'h00500093; prog[1] = 32'h00a00113;
        prog[2] = 32'h002081b3; prog[3] = 32'h00308193;
        prog[4] = 32'h00408213; prog[5] = 32'h00508293;
        prog[6] = 32'h00608313; prog[7] = 32'h00708393;
        test_reset();
        test_halt();
        test_stall();
        test_flush_stall();
        test_out_of_range();
        test_wrap();
        test_read_before_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
`default_nettype wire
